// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
//
// LED sequencer with four modes (shift-left, shift-right, flash, hold).
// A prescaler counts up to a selectable terminal count.  Each time it wraps,
// the LED pattern steps according to the current mode and a one-cycle tick
// is emitted.  Push buttons are edge-detected and select the mode.  A new
// request restarts the prescaler and reloads the LED pattern.
//
// Parameters
//   NB_LEDS   LED vector width (minimum 2)
//   NB_COUNT  prescaler counter width
//   LIM0..3   terminal count for each speed setting (each < 2**NB_COUNT)
//
// Ports
//   clock     rising-edge system clock
//   i_reset   synchronous, active-high reset
//   i_enable  run enable for the prescaler and LED stepping
//   i_speed   selects LIM0..LIM3
//   i_btn     mode requests: [0] shl, [1] shr, [2] flash, [3] hold
//   o_led     registered LED pattern
//   o_tick    registered one-cycle step strobe
//   o_state   current mode: SHL=00, SHR=01, FLASH=10, HOLD=11
// ---------------------------------------------------------------------------
module led_seq_ctrl #(
    parameter int          NB_LEDS  = 4,
    parameter int          NB_COUNT = 32,
    parameter int unsigned LIM0     = 2**23 - 1,
    parameter int unsigned LIM1     = 2**24 - 1,
    parameter int unsigned LIM2     = 2**25 - 1,
    parameter int unsigned LIM3     = 2**26 - 1
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [1:0]         i_speed,
    input  logic [3:0]         i_btn,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_tick,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        SHL   = 2'b00,
        SHR   = 2'b01,
        FLASH = 2'b10,
        HOLD  = 2'b11
    } mode_t;

    localparam logic [NB_LEDS-1:0] LED_INIT = {{(NB_LEDS-1){1'b0}}, 1'b1};

    mode_t                state_reg;
    logic [NB_COUNT-1:0]  count_reg;
    logic [NB_LEDS-1:0]   led_reg;
    logic                 tick_reg;
    logic [3:0]           btn_d;

    logic [3:0]           req;
    logic                 req_valid;
    mode_t                req_mode;
    logic [NB_COUNT-1:0]  lim_sel;
    logic                 wrap;
    logic [NB_LEDS-1:0]   led_step;

    // Rising-edge detection; priority hold > flash > shr > shl.
    always_comb begin
        req       = i_btn & ~btn_d;
        req_valid = |req;
        if (req[3])
            req_mode = HOLD;
        else if (req[2])
            req_mode = FLASH;
        else if (req[1])
            req_mode = SHR;
        else
            req_mode = SHL;
    end

    always_comb begin
        case (i_speed)
            2'd0:    lim_sel = NB_COUNT'(LIM0);
            2'd1:    lim_sel = NB_COUNT'(LIM1);
            2'd2:    lim_sel = NB_COUNT'(LIM2);
            default: lim_sel = NB_COUNT'(LIM3);
        endcase
    end

    // Greater-or-equal so that switching to a shorter limit mid-count wraps
    // immediately instead of running the counter all the way round.
    assign wrap = (count_reg >= lim_sel);

    // Pattern the LEDs take on a wrap in the current mode.
    always_comb begin
        case (state_reg)
            SHL:     led_step = {led_reg[NB_LEDS-2:0], led_reg[NB_LEDS-1]};
            SHR:     led_step = {led_reg[0], led_reg[NB_LEDS-1:1]};
            FLASH:   led_step = ~led_reg;
            default: led_step = led_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        // Loaded in reset too, so a button held through reset is not a request.
        btn_d <= i_btn;
        if (i_reset) begin
            state_reg <= SHL;
            count_reg <= '0;
            led_reg   <= LED_INIT;
            tick_reg  <= 1'b0;
        end else if (req_valid) begin
            // Mode change restarts the prescaler and suppresses any wrap.
            state_reg <= req_mode;
            count_reg <= '0;
            tick_reg  <= 1'b0;
            case (req_mode)
                SHL, SHR: led_reg <= LED_INIT;
                FLASH:    led_reg <= '0;
                default:  led_reg <= led_reg;
            endcase
        end else if (i_enable) begin
            if (wrap) begin
                count_reg <= '0;
                tick_reg  <= 1'b1;
                led_reg   <= led_step;
            end else begin
                count_reg <= count_reg + 1'b1;
                tick_reg  <= 1'b0;
            end
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign o_led   = led_reg;
    assign o_tick  = tick_reg;
    assign o_state = state_reg;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_seq_ctrl
//
// Self-checking bench for led_seq_ctrl.  It runs directed scenarios and
// then randomized stimulus.  Both are compared every cycle against a
// behavioural model that tracks the mode, the LED pattern and the prescaler
// count as plain integers.
// ---------------------------------------------------------------------------
module tb_led_seq_ctrl;

    localparam int NL = 4;
    localparam int NC = 8;
    localparam int L0 = 3;
    localparam int L1 = 1;
    localparam int L2 = 5;
    localparam int L3 = 6;

    logic          clock = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic [1:0]    i_speed;
    logic [3:0]    i_btn;
    logic [NL-1:0] o_led;
    logic          o_tick;
    logic [1:0]    o_state;

    int n_checks = 0;
    int n_fails  = 0;
    int cycle    = 0;

    // Reference model state.
    int          m_mode;
    int          m_cnt;
    logic [3:0]  m_led;
    logic        m_tick;
    logic [3:0]  m_prev;

    led_seq_ctrl #(
        .NB_LEDS (NL),
        .NB_COUNT(NC),
        .LIM0    (L0),
        .LIM1    (L1),
        .LIM2    (L2),
        .LIM3    (L3)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_enable(i_enable),
        .i_speed (i_speed),
        .i_btn   (i_btn),
        .o_led   (o_led),
        .o_tick  (o_tick),
        .o_state (o_state)
    );

    always #5 clock = ~clock;

    function automatic int lim_of(input logic [1:0] s);
        case (s)
            2'd0:    return L0;
            2'd1:    return L1;
            2'd2:    return L2;
            default: return L3;
        endcase
    endfunction

    // Apply the behavioural rules for one rising edge, using the inputs
    // currently driven.
    task automatic model_edge();
        logic [3:0] req;
        int         nm;
        if (i_reset) begin
            m_mode = 0;
            m_cnt  = 0;
            m_led  = 4'd1;
            m_tick = 1'b0;
            m_prev = i_btn;
        end else begin
            req    = i_btn & ~m_prev;
            m_prev = i_btn;
            if (req != 4'd0) begin
                nm = 0;
                for (int k = 0; k < 4; k++)
                    if (req[k]) nm = k;
                m_mode = nm;
                m_cnt  = 0;
                m_tick = 1'b0;
                if (nm < 2)       m_led = 4'd1;
                else if (nm == 2) m_led = 4'd0;
            end else if (i_enable) begin
                if (m_cnt >= lim_of(i_speed)) begin
                    m_cnt  = 0;
                    m_tick = 1'b1;
                    case (m_mode)
                        0: m_led = 4'((m_led * 2) % 16 + m_led / 8);
                        1: m_led = 4'(m_led / 2 + (m_led % 2) * 8);
                        2: m_led = 4'(15 - m_led);
                        default: ;
                    endcase
                end else begin
                    m_cnt  = m_cnt + 1;
                    m_tick = 1'b0;
                end
            end else begin
                m_tick = 1'b0;
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cycle, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock, then compare every output.
    task automatic step(input logic r, input logic e, input logic [1:0] s,
                        input logic [3:0] b);
        i_reset  = r;
        i_enable = e;
        i_speed  = s;
        i_btn    = b;
        @(posedge clock);
        model_edge();
        cycle++;
        #1;
        check_val("led",   32'(o_led),   32'(m_led));
        check_val("tick",  32'(o_tick),  32'(m_tick));
        check_val("state", 32'(o_state), 32'(m_mode));
        $display("cycle %0d rst=%0b en=%0b spd=%0d btn=%b -> led=%b tick=%0b state=%0d",
                 cycle, r, e, s, b, o_led, o_tick, o_state);
    endtask

    initial begin
        int         ticks;
        int         budget;
        logic [3:0] b;

        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_speed  = 2'd0;
        i_btn    = 4'd0;

        // Reset, then free-run shift-left at speed 0.
        step(1, 0, 0, 4'd0);
        step(1, 0, 0, 4'd0);
        check_val("rst_led",   32'(o_led),   32'h1);
        check_val("rst_tick",  32'(o_tick),  32'h0);
        check_val("rst_state", 32'(o_state), 32'h0);
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 4'd0);
            if (o_tick) ticks++;
        end
        check_val("shl_ticks", 32'(ticks), 32'd4);
        check_val("shl_wrap_led", 32'(o_led), 32'h1);

        // Flash request.
        step(0, 1, 0, 4'b0100);
        check_val("flash_state", 32'(o_state), 32'h2);
        check_val("flash_led",   32'(o_led),   32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 4'd0);
        check_val("flash_tick1", 32'(o_led), 32'hF);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 4'd0);
        check_val("flash_tick2", 32'(o_led), 32'h0);

        // All buttons rise together: hold wins, LEDs frozen, ticks continue.
        step(0, 1, 0, 4'b1111);
        check_val("hold_state", 32'(o_state), 32'h3);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 4'b1111);
            if (o_tick) ticks++;
        end
        check_val("hold_ticks", 32'(ticks), 32'd2);
        check_val("hold_led",   32'(o_led), 32'h0);
        step(0, 1, 0, 4'd0);

        // Shift-right, then drop to the short limit while count is 2.
        step(0, 1, 0, 4'b0010);
        check_val("shr_state", 32'(o_state), 32'h1);
        budget = 0;
        while (m_cnt != 2 && budget < 10) begin
            step(0, 1, 0, 4'd0);
            budget++;
        end
        check_val("shr_reach_cnt2", 32'(m_cnt), 32'd2);
        step(0, 1, 1, 4'd0);
        check_val("speed_wrap_tick", 32'(o_tick), 32'h1);
        check_val("speed_wrap_led",  32'(o_led),  32'h8);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 4'd0);

        // Request landing on a wrap edge: reload wins, no tick.
        budget = 0;
        while (m_cnt < L1 && budget < 10) begin
            step(0, 1, 1, 4'd0);
            budget++;
        end
        check_val("wrap_reach", 32'(m_cnt), 32'(L1));
        step(0, 1, 1, 4'b0001);
        check_val("coinc_tick",  32'(o_tick),  32'h0);
        check_val("coinc_led",   32'(o_led),   32'h1);
        check_val("coinc_state", 32'(o_state), 32'h0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 4'd0);
        check_val("disabled_led", 32'(o_led), 32'h1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 4'd0);

        // Reset mid-flash while holding the shift-right button.
        step(0, 1, 0, 4'b0100);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 4'd0);
        step(1, 1, 0, 4'b0010);
        step(1, 1, 0, 4'b0010);
        check_val("midrst_state", 32'(o_state), 32'h0);
        check_val("midrst_led",   32'(o_led),   32'h1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 4'b0010);
        check_val("held_no_req", 32'(o_state), 32'h0);
        step(0, 1, 0, 4'd0);
        step(0, 1, 0, 4'b0010);
        check_val("repress_state", 32'(o_state), 32'h1);

        // Randomized phase.
        b = 4'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) b = 4'($urandom_range(15));
            step(($urandom_range(63) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(3)), b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
